rs_alu: RTL and testbench

- Reservation station feeding the integer ALU; it drives the ALU's issue side and consumes its broadcast.
- Receives decoded, renamed ops from the dispatcher and holds them until both source operands are available.
- Snoops the ALU and load/store result broadcasts to wake waiting operands.
- Sends one ready op per cycle to the ALU through alu_enable plus the operand bundle.

---
 rtl/rs_alu_if.sv | 51 +++++
 rtl/rs_alu.sv | 134 +++++++++++++
 tb/tb_rs_alu.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_alu_if.sv
// Issue, result-broadcast and ALU-dispatch signals of the ALU reservation station.
// master = surrounding pipeline; slave = rs_alu.
interface rs_alu_if #(
  parameter int ROB_W  = 4,
  parameter int OP_W   = 6,
  parameter int DATA_W = 32
);
  logic              rdy;
  logic              clear;
  logic              issue_valid;
  logic [OP_W-1:0]   issue_op;
  logic [DATA_W-1:0] issue_pc;
  logic [DATA_W-1:0] issue_imm;
  logic [ROB_W-1:0]  issue_rd_rename;
  logic              issue_qj_busy;
  logic [ROB_W-1:0]  issue_qj;
  logic [DATA_W-1:0] issue_vj;
  logic              issue_qk_busy;
  logic [ROB_W-1:0]  issue_qk;
  logic [DATA_W-1:0] issue_vk;
  logic              rs_full;
  logic              alu_broadcast;
  logic [DATA_W-1:0] alu_result;
  logic [ROB_W-1:0]  alu_rd_rename;
  logic              lsb_broadcast;
  logic [DATA_W-1:0] lsb_result;
  logic [ROB_W-1:0]  lsb_rd_rename;
  logic              alu_enable;
  logic [OP_W-1:0]   out_op;
  logic [DATA_W-1:0] out_pc;
  logic [DATA_W-1:0] out_imm;
  logic [DATA_W-1:0] out_rs1_value;
  logic [DATA_W-1:0] out_rs2_value;
  logic [ROB_W-1:0]  out_rd_rename;

  modport master (
    output rdy, clear, issue_valid, issue_op, issue_pc, issue_imm, issue_rd_rename,
           issue_qj_busy, issue_qj, issue_vj, issue_qk_busy, issue_qk, issue_vk,
           alu_broadcast, alu_result, alu_rd_rename, lsb_broadcast, lsb_result, lsb_rd_rename,
    input  rs_full, alu_enable, out_op, out_pc, out_imm, out_rs1_value, out_rs2_value,
           out_rd_rename
  );

  modport slave (
    input  rdy, clear, issue_valid, issue_op, issue_pc, issue_imm, issue_rd_rename,
           issue_qj_busy, issue_qj, issue_vj, issue_qk_busy, issue_qk, issue_vk,
           alu_broadcast, alu_result, alu_rd_rename, lsb_broadcast, lsb_result, lsb_rd_rename,
    output rs_full, alu_enable, out_op, out_pc, out_imm, out_rs1_value, out_rs2_value,
           out_rd_rename
  );
endinterface

// File: rtl/rs_alu.sv
// ALU reservation station: holds renamed ops until operands arrive, one dispatch per cycle.
// Ready op dispatches one edge after it becomes ready; rdy=0 freezes everything; issue ignored when full.
module rs_alu #(
  parameter int RS_SIZE = 16,
  parameter int ROB_W   = 4,
  parameter int OP_W    = 6,
  parameter int DATA_W  = 32
) (
  input logic     clk,
  input logic     rst,
  rs_alu_if.slave bus
);
  localparam int IDX_W = $clog2(RS_SIZE);

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] imm;
    logic [ROB_W-1:0]  rd;
    logic              qj_busy;
    logic [ROB_W-1:0]  qj;
    logic [DATA_W-1:0] vj;
    logic              qk_busy;
    logic [ROB_W-1:0]  qk;
    logic [DATA_W-1:0] vk;
  } ent_t;

  logic [RS_SIZE-1:0] busy;
  logic [RS_SIZE-1:0] busy_nxt;
  logic [RS_SIZE-1:0] ready;
  ent_t               ent      [RS_SIZE];
  ent_t               wake_ent [RS_SIZE];
  ent_t               new_ent;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   disp_idx;
  logic               has_ready;
  logic               issue_ok;

  // Returns {still_pending, value}; the ALU broadcast wins a (illegal) tag collision with the LSB.
  function automatic logic [DATA_W:0] snoop(
    input logic pend, input logic [ROB_W-1:0] tag, input logic [DATA_W-1:0] val,
    input logic a_vld, input logic [ROB_W-1:0] a_tag, input logic [DATA_W-1:0] a_dat,
    input logic l_vld, input logic [ROB_W-1:0] l_tag, input logic [DATA_W-1:0] l_dat);
    if (pend && a_vld && (tag == a_tag)) return {1'b0, a_dat};
    if (pend && l_vld && (tag == l_tag)) return {1'b0, l_dat};
    return {pend, val};
  endfunction

  assign bus.rs_full = &busy;
  assign issue_ok    = bus.issue_valid && !(&busy);

  always_comb begin
    free_idx  = '0;
    disp_idx  = '0;
    has_ready = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      ready[i] = busy[i] && !ent[i].qj_busy && !ent[i].qk_busy;
      if (!busy[i]) free_idx = IDX_W'(i);
      if (ready[i]) begin
        disp_idx  = IDX_W'(i);
        has_ready = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      wake_ent[i] = ent[i];
      {wake_ent[i].qj_busy, wake_ent[i].vj} = snoop(ent[i].qj_busy, ent[i].qj, ent[i].vj,
          bus.alu_broadcast, bus.alu_rd_rename, bus.alu_result,
          bus.lsb_broadcast, bus.lsb_rd_rename, bus.lsb_result);
      {wake_ent[i].qk_busy, wake_ent[i].vk} = snoop(ent[i].qk_busy, ent[i].qk, ent[i].vk,
          bus.alu_broadcast, bus.alu_rd_rename, bus.alu_result,
          bus.lsb_broadcast, bus.lsb_rd_rename, bus.lsb_result);
    end
  end

  always_comb begin
    new_ent    = '0;
    new_ent.op = bus.issue_op;
    new_ent.pc = bus.issue_pc;
    new_ent.imm = bus.issue_imm;
    new_ent.rd = bus.issue_rd_rename;
    new_ent.qj = bus.issue_qj;
    new_ent.qk = bus.issue_qk;
    {new_ent.qj_busy, new_ent.vj} = snoop(bus.issue_qj_busy, bus.issue_qj, bus.issue_vj,
        bus.alu_broadcast, bus.alu_rd_rename, bus.alu_result,
        bus.lsb_broadcast, bus.lsb_rd_rename, bus.lsb_result);
    {new_ent.qk_busy, new_ent.vk} = snoop(bus.issue_qk_busy, bus.issue_qk, bus.issue_vk,
        bus.alu_broadcast, bus.alu_rd_rename, bus.alu_result,
        bus.lsb_broadcast, bus.lsb_rd_rename, bus.lsb_result);
  end

  // The dispatched slot and the issue slot are always distinct: one is busy, the other free.
  always_comb begin
    busy_nxt = busy;
    if (has_ready) busy_nxt[disp_idx] = 1'b0;
    if (issue_ok)  busy_nxt[free_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy              <= '0;
      bus.alu_enable    <= 1'b0;
      bus.out_op        <= '0;
      bus.out_pc        <= '0;
      bus.out_imm       <= '0;
      bus.out_rs1_value <= '0;
      bus.out_rs2_value <= '0;
      bus.out_rd_rename <= '0;
      for (int i = 0; i < RS_SIZE; i++) ent[i] <= '0;
    end else if (bus.rdy) begin
      if (bus.clear) begin
        busy           <= '0;
        bus.alu_enable <= 1'b0;
      end else begin
        busy           <= busy_nxt;
        bus.alu_enable <= has_ready;
        if (has_ready) begin
          bus.out_op        <= ent[disp_idx].op;
          bus.out_pc        <= ent[disp_idx].pc;
          bus.out_imm       <= ent[disp_idx].imm;
          bus.out_rs1_value <= ent[disp_idx].vj;
          bus.out_rs2_value <= ent[disp_idx].vk;
          bus.out_rd_rename <= ent[disp_idx].rd;
        end
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy[i])                                    ent[i] <= wake_ent[i];
          else if (issue_ok && (free_idx == IDX_W'(i)))   ent[i] <= new_ent;
        end
      end
    end
  end
endmodule

// File: tb/tb_rs_alu.sv
// Directed and randomized bench for rs_alu against a slot-list reference model.
module tb_rs_alu;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  rs_alu_if bus ();
  rs_alu dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    bit          busy;
    logic [5:0]  op;
    logic [31:0] pc, imm;
    logic [3:0]  rd;
    bit          qjb;
    logic [3:0]  qj;
    logic [31:0] vj;
    bit          qkb;
    logic [3:0]  qk;
    logic [31:0] vk;
  } slot_t;

  slot_t        m [16];
  bit           m_en;
  logic [137:0] m_out;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_full();
    foreach (m[i]) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  // An operand still waiting picks up a matching broadcast; ALU takes priority over LSB.
  function automatic logic [32:0] resolve(input bit b, input logic [3:0] q, input logic [31:0] v);
    if (b && bus.alu_broadcast && bus.alu_rd_rename == q) return {1'b0, bus.alu_result};
    if (b && bus.lsb_broadcast && bus.lsb_rd_rename == q) return {1'b0, bus.lsb_result};
    return {b, v};
  endfunction

  task automatic model_reset();
    foreach (m[i]) m[i] = '{default: '0};
    m_en  = 1'b0;
    m_out = '0;
  endtask

  task automatic model_edge();
    int d = -1;
    int f = -1;
    slot_t s;
    if (!rst) begin model_reset(); return; end
    if (!bus.rdy) return;
    if (bus.clear) begin
      foreach (m[i]) m[i].busy = 1'b0;
      m_en = 1'b0;
      return;
    end
    for (int i = 15; i >= 0; i--) begin
      if (m[i].busy && !m[i].qjb && !m[i].qkb) d = i;
      if (!m[i].busy) f = i;
    end
    foreach (m[i]) if (m[i].busy) begin
      {m[i].qjb, m[i].vj} = resolve(m[i].qjb, m[i].qj, m[i].vj);
      {m[i].qkb, m[i].vk} = resolve(m[i].qkb, m[i].qk, m[i].vk);
    end
    if (d >= 0) begin
      m_out = {m[d].op, m[d].pc, m[d].imm, m[d].vj, m[d].vk, m[d].rd};
      m_en = 1'b1;
      m[d].busy = 1'b0;
    end else begin
      m_en = 1'b0;
    end
    if (bus.issue_valid && f >= 0) begin
      s.busy = 1'b1;  s.op = bus.issue_op;  s.pc = bus.issue_pc;  s.imm = bus.issue_imm;
      s.rd = bus.issue_rd_rename;  s.qj = bus.issue_qj;  s.qk = bus.issue_qk;
      {s.qjb, s.vj} = resolve(bus.issue_qj_busy, bus.issue_qj, bus.issue_vj);
      {s.qkb, s.vk} = resolve(bus.issue_qk_busy, bus.issue_qk, bus.issue_vk);
      m[f] = s;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("alu_enable", 160'(bus.alu_enable), 160'(m_en));
    chk("rs_full", 160'(bus.rs_full), 160'(m_full()));
    chk("out_bundle", 160'({bus.out_op, bus.out_pc, bus.out_imm, bus.out_rs1_value,
                            bus.out_rs2_value, bus.out_rd_rename}), 160'(m_out));
  endtask

  task automatic set_idle();
    bus.rdy = 1'b1;  bus.clear = 1'b0;  bus.issue_valid = 1'b0;
    bus.issue_op = '0;  bus.issue_pc = '0;  bus.issue_imm = '0;  bus.issue_rd_rename = '0;
    bus.issue_qj_busy = 1'b0;  bus.issue_qj = '0;  bus.issue_vj = '0;
    bus.issue_qk_busy = 1'b0;  bus.issue_qk = '0;  bus.issue_vk = '0;
    bus.alu_broadcast = 1'b0;  bus.alu_result = '0;  bus.alu_rd_rename = '0;
    bus.lsb_broadcast = 1'b0;  bus.lsb_result = '0;  bus.lsb_rd_rename = '0;
  endtask

  task automatic set_issue(input logic [5:0] op, input logic [3:0] rd,
                           input bit qjb, input logic [3:0] qj, input logic [31:0] vj,
                           input bit qkb, input logic [3:0] qk, input logic [31:0] vk);
    bus.issue_valid = 1'b1;  bus.issue_op = op;  bus.issue_rd_rename = rd;
    bus.issue_pc = $urandom;  bus.issue_imm = $urandom;
    bus.issue_qj_busy = qjb;  bus.issue_qj = qj;  bus.issue_vj = vj;
    bus.issue_qk_busy = qkb;  bus.issue_qk = qk;  bus.issue_vk = vk;
  endtask

  initial begin
    set_idle();
    model_reset();
    tick();
    chk("reset_enable", 160'(bus.alu_enable), 160'(0));
    chk("reset_full", 160'(bus.rs_full), 160'(0));
    rst = 1'b1;

    // Ready op: dispatched one edge after issue, strobe drops the edge after.
    set_issue(6'h01, 4'd3, 0, 4'd0, 32'd5, 0, 4'd0, 32'd7);
    tick();
    set_idle();
    tick();
    chk("ready_en", 160'(bus.alu_enable), 160'(1));
    chk("ready_rs1", 160'(bus.out_rs1_value), 160'(5));
    chk("ready_rs2", 160'(bus.out_rs2_value), 160'(7));
    chk("ready_rd", 160'(bus.out_rd_rename), 160'(3));
    tick();
    chk("ready_en_drop", 160'(bus.alu_enable), 160'(0));

    // Wakeup via ALU broadcast two cycles after issue.
    set_issue(6'h02, 4'd5, 1, 4'd9, 32'd0, 0, 4'd0, 32'd2);
    tick();
    set_idle();
    tick();
    bus.alu_broadcast = 1'b1;  bus.alu_rd_rename = 4'd9;  bus.alu_result = 32'h1234;
    tick();
    chk("wake_not_yet", 160'(bus.alu_enable), 160'(0));
    set_idle();
    tick();
    chk("wake_en", 160'(bus.alu_enable), 160'(1));
    chk("wake_rs1", 160'(bus.out_rs1_value), 160'(32'h1234));

    // Issue-time forwarding from the LSB broadcast.
    set_issue(6'h03, 4'd6, 0, 4'd0, 32'd1, 1, 4'd4, 32'd0);
    bus.lsb_broadcast = 1'b1;  bus.lsb_rd_rename = 4'd4;  bus.lsb_result = 32'hFF;
    tick();
    set_idle();
    tick();
    chk("fwd_en", 160'(bus.alu_enable), 160'(1));
    chk("fwd_rs2", 160'(bus.out_rs2_value), 160'(32'hFF));
    tick();

    // Fill all entries, overflow issue ignored, then drain in index order.
    for (int i = 0; i < 16; i++) begin
      set_issue(6'h04, 4'(i), 1, 4'd1, 32'd0, 0, 4'd0, 32'(i));
      tick();
    end
    chk("full_set", 160'(bus.rs_full), 160'(1));
    set_issue(6'h05, 4'hA, 0, 4'd0, 32'd9, 0, 4'd0, 32'd9);
    tick();
    set_idle();
    bus.alu_broadcast = 1'b1;  bus.alu_rd_rename = 4'd1;  bus.alu_result = 32'hBEEF;
    tick();
    chk("full_after_wake", 160'(bus.rs_full), 160'(1));
    set_idle();
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("drain_en", 160'(bus.alu_enable), 160'(1));
      chk("drain_order", 160'(bus.out_rd_rename), 160'(i));
      chk("drain_rs1", 160'(bus.out_rs1_value), 160'(32'hBEEF));
      if (i == 0) chk("full_drop", 160'(bus.rs_full), 160'(0));
    end
    tick();
    chk("overflow_ignored", 160'(bus.alu_enable), 160'(0));

    // Flush with 5 busy entries plus a same-cycle issue and broadcast.
    for (int i = 0; i < 5; i++) begin
      set_issue(6'h06, 4'(i), 1, 4'd2, 32'd0, 0, 4'd0, 32'd0);
      tick();
    end
    set_issue(6'h07, 4'd8, 0, 4'd0, 32'd1, 0, 4'd0, 32'd1);
    bus.clear = 1'b1;
    bus.alu_broadcast = 1'b1;  bus.alu_rd_rename = 4'd2;  bus.alu_result = 32'd77;
    tick();
    chk("flush_en", 160'(bus.alu_enable), 160'(0));
    set_idle();
    bus.alu_broadcast = 1'b1;  bus.alu_rd_rename = 4'd2;  bus.alu_result = 32'd77;
    tick();
    set_idle();
    tick();
    chk("flush_no_dispatch", 160'(bus.alu_enable), 160'(0));

    // Stall holds a ready entry and a raised strobe.
    set_issue(6'h08, 4'd6, 0, 4'd0, 32'd11, 0, 4'd0, 32'd12);
    tick();
    set_idle();
    bus.rdy = 1'b0;
    tick();
    tick();
    chk("stall_no_dispatch", 160'(bus.alu_enable), 160'(0));
    bus.rdy = 1'b1;
    tick();
    chk("stall_release", 160'(bus.alu_enable), 160'(1));
    chk("stall_rd", 160'(bus.out_rd_rename), 160'(6));
    bus.rdy = 1'b0;
    tick();
    chk("stall_hold_en", 160'(bus.alu_enable), 160'(1));
    bus.rdy = 1'b1;
    tick();

    // Async reset mid-operation with 3 waiting entries and a live strobe.
    for (int i = 0; i < 3; i++) begin
      set_issue(6'h09, 4'(i), 1, 4'd3, 32'd0, 0, 4'd0, 32'd0);
      tick();
    end
    set_issue(6'h0A, 4'd9, 0, 4'd0, 32'd21, 0, 4'd0, 32'd22);
    tick();
    set_idle();
    tick();
    chk("pre_reset_en", 160'(bus.alu_enable), 160'(1));
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("async_rst_en", 160'(bus.alu_enable), 160'(0));
    chk("async_rst_full", 160'(bus.rs_full), 160'(0));
    chk("async_rst_out", 160'({bus.out_op, bus.out_pc, bus.out_imm, bus.out_rs1_value,
                               bus.out_rs2_value, bus.out_rd_rename}), 160'(0));
    tick();
    rst = 1'b1;
    bus.alu_broadcast = 1'b1;  bus.alu_rd_rename = 4'd3;  bus.alu_result = 32'd5;
    tick();
    set_idle();
    tick();
    chk("post_reset_no_dispatch", 160'(bus.alu_enable), 160'(0));

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      set_idle();
      bus.rdy   = ($urandom_range(0, 9) != 0);
      bus.clear = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 1) == 1 && !m_full())
        set_issue(6'($urandom), 4'($urandom), bit'($urandom_range(0, 1)), 4'($urandom), $urandom,
                  bit'($urandom_range(0, 1)), 4'($urandom), $urandom);
      bus.alu_broadcast = ($urandom_range(0, 2) == 0);
      bus.alu_rd_rename = 4'($urandom);
      bus.alu_result    = $urandom;
      bus.lsb_broadcast = ($urandom_range(0, 2) == 0);
      bus.lsb_rd_rename = 4'($urandom);
      bus.lsb_result    = $urandom;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
